// File: rtl/vector_pkg.sv
// Shared types and constants for the vector command receiver.
// VECTOR_FRAME_CHECKSUM_EN adds the CHK state to the state encoding.
package vector_pkg;
    localparam int REC_BYTES = 4;
    localparam int COORD_W   = 12;
    localparam int RGB_W     = 3;

    // Field positions inside record byte 3
    localparam int B3_LAST   = 7;
    localparam int B3_BLANK  = 6;
    localparam int B3_RGB_HI = 5;
    localparam int B3_RGB_LO = 3;

`ifdef VECTOR_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_REC = 2'd1, ST_CHK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_REC = 2'd1} state_t;
`endif

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RGB_W-1:0]   rgb;
        logic               blank;
        logic               last;
    } point_t;
endpackage

// File: rtl/vector_cmd_rx_if.sv
// Byte-in / point-out bus of vector_cmd_rx. master drives bytes and
// ready, slave is the receiver.
interface vector_cmd_rx_if;
    import vector_pkg::*;

    logic               i_Rx_DV;
    logic [7:0]         i_Rx_Byte;
    logic               i_Pt_Ready;
    logic               o_Pt_Valid;
    logic [COORD_W-1:0] o_Pt_X;
    logic [COORD_W-1:0] o_Pt_Y;
    logic [RGB_W-1:0]   o_Pt_Rgb;
    logic               o_Pt_Blank;
    logic               o_Pt_Last;
    logic               o_Frame_Done;
    logic               o_Frame_Err;
    logic               o_Overflow;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Pt_Ready,
        input  o_Pt_Valid, o_Pt_X, o_Pt_Y, o_Pt_Rgb, o_Pt_Blank, o_Pt_Last,
               o_Frame_Done, o_Frame_Err, o_Overflow
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Pt_Ready,
        output o_Pt_Valid, o_Pt_X, o_Pt_Y, o_Pt_Rgb, o_Pt_Blank, o_Pt_Last,
               o_Frame_Done, o_Frame_Err, o_Overflow
    );
endinterface

// File: rtl/byte_watchdog.sv
// Inter-byte idle timer: expires after TIMEOUT_CLKS-1 quiet clocks while
// enabled. A clear on the expiry cycle suppresses the expiry.
module byte_watchdog #(
    parameter int TIMEOUT_CLKS = 2300
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = ($clog2(TIMEOUT_CLKS) > 0) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] idle_cnt;

    assign expire = enable && !clear && (idle_cnt == LIMIT);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)
            idle_cnt <= '0;
        else if (!enable || clear || expire)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
endmodule

// File: rtl/vector_cmd_rx.sv
// Frames a UART byte stream into vector points: zero-run sync, 4-byte
// records, one-deep output register. VECTOR_FRAME_CHECKSUM_EN adds an XOR check byte.
module vector_cmd_rx
    import vector_pkg::*;
#(
    parameter int SYNC_LEN     = 4,
    parameter int TIMEOUT_CLKS = 2300
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    vector_cmd_rx_if.slave  bus
);
    localparam int ZW = $clog2(SYNC_LEN + 1);

    state_t        state, state_nxt;
    logic [ZW-1:0] zero_cnt;
    logic [1:0]    byte_idx;
    logic [7:0]    b0_q, b1_q, b2_q;
    point_t        pt_q;
    logic          pt_vld;
    logic          done_q, err_q, ovf_q;
    logic          sync_hit, load_pt, ovf_set, done_set, err_set;
    logic          wd_expire;
`ifdef VECTOR_FRAME_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    byte_watchdog #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_wd (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .clear   (bus.i_Rx_DV),
        .enable  (state != ST_HUNT),
        .expire  (wd_expire)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= ST_HUNT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sync_hit  = 1'b0;
        load_pt   = 1'b0;
        ovf_set   = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (bus.i_Rx_DV && bus.i_Rx_Byte == 8'h00 && zero_cnt == ZW'(SYNC_LEN - 1)) begin
                    sync_hit  = 1'b1;
                    state_nxt = ST_REC;
                end
            end
            ST_REC: begin
                if (bus.i_Rx_DV) begin
                    if (byte_idx == 2'(REC_BYTES - 1)) begin
                        // A full record is dropped if the held point is not leaving this cycle
                        if (!pt_vld || bus.i_Pt_Ready) load_pt = 1'b1;
                        else                           ovf_set = 1'b1;
                        if (bus.i_Rx_Byte[B3_LAST]) begin
`ifdef VECTOR_FRAME_CHECKSUM_EN
                            state_nxt = ST_CHK;
`else
                            state_nxt = ST_HUNT;
                            done_set  = 1'b1;
`endif
                        end
                    end
                end else if (wd_expire) begin
                    state_nxt = ST_HUNT;
                    err_set   = 1'b1;
                end
            end
`ifdef VECTOR_FRAME_CHECKSUM_EN
            ST_CHK: begin
                if (bus.i_Rx_DV) begin
                    state_nxt = ST_HUNT;
                    if (bus.i_Rx_Byte == csum_q) done_set = 1'b1;
                    else                         err_set  = 1'b1;
                end else if (wd_expire) begin
                    state_nxt = ST_HUNT;
                    err_set   = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            zero_cnt <= '0;
            byte_idx <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            b2_q     <= '0;
            pt_q     <= '0;
            pt_vld   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= done_set;
            err_q  <= err_set;
            ovf_q  <= ovf_set;

            if (state == ST_HUNT && bus.i_Rx_DV)
                zero_cnt <= (bus.i_Rx_Byte == 8'h00 && !sync_hit) ? zero_cnt + 1'b1 : '0;

            // Leaving REC for any reason discards whatever partial record was collected
            if (state != ST_REC)
                byte_idx <= '0;
            else if (bus.i_Rx_DV)
                byte_idx <= byte_idx + 1'b1;

            if (state == ST_REC && bus.i_Rx_DV) begin
                case (byte_idx)
                    2'd0:    b0_q <= bus.i_Rx_Byte;
                    2'd1:    b1_q <= bus.i_Rx_Byte;
                    2'd2:    b2_q <= bus.i_Rx_Byte;
                    default: ;
                endcase
            end

            if (load_pt) begin
                pt_q.x     <= {b0_q, b1_q[7:4]};
                pt_q.y     <= {b1_q[3:0], b2_q};
                pt_q.rgb   <= bus.i_Rx_Byte[B3_RGB_HI:B3_RGB_LO];
                pt_q.blank <= bus.i_Rx_Byte[B3_BLANK];
                pt_q.last  <= bus.i_Rx_Byte[B3_LAST];
                pt_vld     <= 1'b1;
            end else if (pt_vld && bus.i_Pt_Ready) begin
                pt_vld <= 1'b0;
            end
        end
    end

`ifdef VECTOR_FRAME_CHECKSUM_EN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)
            csum_q <= '0;
        else if (sync_hit)
            csum_q <= '0;
        else if (state == ST_REC && bus.i_Rx_DV)
            csum_q <= csum_q ^ bus.i_Rx_Byte;
    end
`endif

    assign bus.o_Pt_Valid   = pt_vld;
    assign bus.o_Pt_X       = pt_q.x;
    assign bus.o_Pt_Y       = pt_q.y;
    assign bus.o_Pt_Rgb     = pt_q.rgb;
    assign bus.o_Pt_Blank   = pt_q.blank;
    assign bus.o_Pt_Last    = pt_q.last;
    assign bus.o_Frame_Done = done_q;
    assign bus.o_Frame_Err  = err_q;
    assign bus.o_Overflow   = ovf_q;
endmodule

// File: tb/tb_vector_cmd_rx.sv
// Self-checking bench for vector_cmd_rx: record table plus sync, overflow,
// watchdog, reset and (with VECTOR_FRAME_CHECKSUM_EN) checksum sequences.
module tb_vector_cmd_rx;
    import vector_pkg::*;

    localparam int SYNC_LEN     = 4;
    localparam int TIMEOUT_CLKS = 2300;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;

    vector_cmd_rx_if bus ();

    vector_cmd_rx #(.SYNC_LEN(SYNC_LEN), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    int checks   = 0;
    int failures = 0;
    int n_done = 0, n_err = 0, n_ovf = 0, n_pts = 0;
    point_t     sb_q[$];
    logic [7:0] frame_x = 8'h00;

    typedef struct {
        logic [31:0] rec;
        point_t      exp;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: count pulses, compare every accepted point
    always @(negedge i_Clock) begin
        if (!i_Reset) begin
            if (bus.o_Frame_Done) n_done++;
            if (bus.o_Frame_Err)  n_err++;
            if (bus.o_Overflow)   n_ovf++;
            if (bus.o_Pt_Valid && bus.i_Pt_Ready) begin
                n_pts++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_point actual=%0h required=none",
                             {bus.o_Pt_X, bus.o_Pt_Y, bus.o_Pt_Rgb, bus.o_Pt_Blank, bus.o_Pt_Last});
                end else begin
                    check("point", {bus.o_Pt_X, bus.o_Pt_Y, bus.o_Pt_Rgb, bus.o_Pt_Blank, bus.o_Pt_Last},
                          sb_q.pop_front());
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following one idle cycle
    task automatic send(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        frame_x       = frame_x ^ b;
        @(posedge i_Clock); #1;
        bus.i_Rx_DV   = 1'b0;
        @(posedge i_Clock); #1;
    endtask

    task automatic sync();
        repeat (SYNC_LEN) send(8'h00);
        frame_x = 8'h00;
    endtask

    task automatic send_rec(input logic [31:0] rec);
        send(rec[31:24]);
        send(rec[23:16]);
        send(rec[15:8]);
        send(rec[7:0]);
    endtask

    task automatic end_frame();
`ifdef VECTOR_FRAME_CHECKSUM_EN
        send(frame_x);
`endif
    endtask

    task automatic settle();
        repeat (4) @(posedge i_Clock);
        #1;
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0, e0, o0, p0;

        vecs[0] = '{32'h12345600, {12'h123, 12'h456, 3'b000, 1'b0, 1'b0}};
        vecs[1] = '{32'h00000038, {12'h000, 12'h000, 3'b111, 1'b0, 1'b0}};
        vecs[2] = '{32'hFFFFFF78, {12'hFFF, 12'hFFF, 3'b111, 1'b1, 1'b0}};
        vecs[3] = '{32'hABCDEF50, {12'hABC, 12'hDEF, 3'b010, 1'b1, 1'b0}};
        vecs[4] = '{32'h800F01A8, {12'h800, 12'hF01, 3'b101, 1'b0, 1'b1}};

        bus.i_Rx_DV    = 1'b0;
        bus.i_Rx_Byte  = 8'h00;
        bus.i_Pt_Ready = 1'b1;

        repeat (3) @(posedge i_Clock);
        #1;
        check("rst_valid", bus.o_Pt_Valid, 0);
        check("rst_fields", {bus.o_Pt_X, bus.o_Pt_Y, bus.o_Pt_Rgb, bus.o_Pt_Blank, bus.o_Pt_Last}, 0);
        check("rst_pulses", {bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Overflow}, 0);
        i_Reset = 1'b0;
        @(posedge i_Clock); #1;

        // Record table, one frame, ready held high
        d0 = n_done; p0 = n_pts;
        sync();
        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].exp);
            send_rec(vecs[i].rec);
        end
        end_frame();
        settle();
        check("tbl_points", n_pts - p0, 5);
        check("tbl_done", n_done - d0, 1);

        // Basic frame; E0 decodes to Last, Blank and R
        d0 = n_done;
        sync();
        sb_q.push_back({12'h123, 12'h456, 3'b100, 1'b1, 1'b1});
        send(8'h12); send(8'h34); send(8'h56);
        bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = 8'hE0; frame_x = frame_x ^ 8'hE0;
        @(posedge i_Clock); #1;
        bus.i_Rx_DV = 1'b0;
        check("lat1_valid", bus.o_Pt_Valid, 1);
        check("lat1_xy", {bus.o_Pt_X, bus.o_Pt_Y}, 24'h123456);
        check("lat1_flags", {bus.o_Pt_Rgb, bus.o_Pt_Blank, bus.o_Pt_Last}, {3'b100, 1'b1, 1'b1});
`ifndef VECTOR_FRAME_CHECKSUM_EN
        check("lat1_done", bus.o_Frame_Done, 1);
`endif
        @(posedge i_Clock); #1;
        end_frame();
        settle();
        check("basic_done", n_done - d0, 1);
        // Back in HUNT: an unsynchronised record is ignored
        p0 = n_pts;
        send_rec(32'h12345678);
        settle();
        check("hunt_ignores", n_pts - p0, 0);

        // Short zero run, then a broken run, then a real sync
        p0 = n_pts;
        send(8'h00); send(8'h00); send(8'h00);
        send_rec(32'h12345680);
        settle();
        check("short_sync", n_pts - p0, 0);
        d0 = n_done;
        send(8'h00); send(8'h00); send(8'h07);
        sync();
        sb_q.push_back({12'hABC, 12'hDEF, 3'b000, 1'b0, 1'b1});
        send_rec(32'hABCDEF80);
        end_frame();
        settle();
        check("resync_points", n_pts - p0, 1);
        check("resync_done", n_done - d0, 1);

        // Overflow while held, then replace on the acceptance edge
        bus.i_Pt_Ready = 1'b0;
        p0 = n_pts; o0 = n_ovf;
        sync();
        send_rec(32'h11111100);
        check("hold_valid", bus.o_Pt_Valid, 1);
        send_rec(32'h22222200);
        check("ovf_pulse", n_ovf - o0, 1);
        check("ovf_keeps", {bus.o_Pt_X, bus.o_Pt_Y}, 24'h111111);
        send(8'h33); send(8'h33); send(8'h33);
        sb_q.push_back({12'h111, 12'h111, 3'b000, 1'b0, 1'b0});
        sb_q.push_back({12'h333, 12'h333, 3'b000, 1'b0, 1'b1});
        bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = 8'h80; bus.i_Pt_Ready = 1'b1;
        frame_x = frame_x ^ 8'h80;
        @(posedge i_Clock); #1;
        bus.i_Rx_DV = 1'b0;
        @(posedge i_Clock); #1;
        end_frame();
        settle();
        check("replace_no_ovf", n_ovf - o0, 1);
        check("replace_points", n_pts - p0, 2);

        // Watchdog abort mid-record
        e0 = n_err; p0 = n_pts;
        sync();
        send(8'h12); send(8'h34);
        repeat (TIMEOUT_CLKS + 100) @(posedge i_Clock);
        #1;
        check("wd_err_once", n_err - e0, 1);
        check("wd_no_point", n_pts - p0, 0);

        // Byte arriving on the expiry cycle wins
        e0 = n_err; d0 = n_done;
        sync();
        send(8'h45);
        repeat (TIMEOUT_CLKS - 2) @(posedge i_Clock);
        #1;
        sb_q.push_back({12'h456, 12'h789, 3'b011, 1'b0, 1'b1});
        send(8'h67); send(8'h89); send(8'h98);
        end_frame();
        settle();
        check("wd_race_err", n_err - e0, 0);
        check("wd_race_done", n_done - d0, 1);

        // Reset mid-record with a point held
        bus.i_Pt_Ready = 1'b0;
        sync();
        send_rec(32'h11111100);
        send(8'h12); send(8'h34); send(8'h56);
        i_Reset = 1'b1;
        #1;
        check("mid_rst_valid", bus.o_Pt_Valid, 0);
        check("mid_rst_fields", {bus.o_Pt_X, bus.o_Pt_Y, bus.o_Pt_Rgb, bus.o_Pt_Blank, bus.o_Pt_Last}, 0);
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
        bus.i_Pt_Ready = 1'b1;
        p0 = n_pts; d0 = n_done;
        send(8'hE0);
        settle();
        check("post_rst_no_point", n_pts - p0, 0);
        sync();
        sb_q.push_back({12'h123, 12'h456, 3'b000, 1'b0, 1'b1});
        send_rec(32'h12345680);
        end_frame();
        settle();
        check("post_rst_frame", n_done - d0, 1);

`ifdef VECTOR_FRAME_CHECKSUM_EN
        // 01^02^03^80 = 80
        d0 = n_done; e0 = n_err;
        sync();
        sb_q.push_back({12'h010, 12'h203, 3'b000, 1'b0, 1'b1});
        send_rec(32'h01020380);
        send(8'h80);
        settle();
        check("csum_match", n_done - d0, 1);
        sync();
        sb_q.push_back({12'h010, 12'h203, 3'b000, 1'b0, 1'b1});
        send_rec(32'h01020380);
        send(8'h83);
        settle();
        check("csum_mismatch", n_err - e0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
